// File: rtl/break_detect_pkg.sv
// -----------------------------------------------------------------------------
// break_detect_pkg
// Shared definitions for the serial break detector (and its transmit-side
// counterpart): FSM state encoding, default break threshold and the
// bit-time derivation used by both ends so they agree on what a bit-time is.
// -----------------------------------------------------------------------------
package break_detect_pkg;

  // Detector FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOW   = 2'd1,
    ST_BREAK = 2'd2
  } state_t;

  // Consecutive low bit-times that qualify as a break.
  localparam int DEF_BREAK_BITS = 10;

  // Clock cycles per bit-time: floor(sysclk / baudrate), never below 2.
  function automatic int calc_bit_cycles(input int sysclk, input int baudrate);
    int q;
    if (baudrate <= 0) begin
      q = 2;
    end else begin
      q = sysclk / baudrate;
    end
    if (q < 2) begin
      q = 2;
    end
    return q;
  endfunction

endpackage

// File: rtl/break_detect_baud_tick.sv
// -----------------------------------------------------------------------------
// baud_tick
// Bit-time cycle counter. Counts 0..BIT_CYCLES-1 while enabled and emits a
// one-cycle bit_tick on the wrap. Clear has priority over enable.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_clr    synchronous clear of the cycle counter
//   i_en     count enable
//   o_tick   high in the cycle whose count wraps (combinational)
// -----------------------------------------------------------------------------
module baud_tick #(
  parameter  int BIT_CYCLES = 104,
  localparam int CW         = $clog2(BIT_CYCLES)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cyc;
  logic          w_wrap;

  assign w_wrap = i_en && (r_cyc == CYC_LAST);
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cyc <= '0;
    end else if (i_clr) begin
      r_cyc <= '0;
    end else if (i_en) begin
      if (w_wrap) begin
        r_cyc <= '0;
      end else begin
        r_cyc <= r_cyc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/break_detect.sv
// -----------------------------------------------------------------------------
// break_detect
// Watches the PC receive line and reports a break: the line held low for at
// least BREAK_BITS bit-times. Provides a level/pulse view for the control
// path and a one-deep event register carrying the break length in whole
// bit-times (saturating at all-ones).
//
// Optional build macro:
//   BREAK_GLITCH_FILTER_EN  adds a 3-sample majority filter after the
//                           synchronizer (one extra cycle of latency) so that
//                           single-cycle glitches neither start nor end a run.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_rxd        raw asynchronous RX line, idle high
//   o_break      high while a break is in progress
//   o_start      one-cycle pulse when a break qualifies
//   o_end        one-cycle pulse when the line returns high after a break
//   o_evt_valid  a completed-break event is held
//   o_evt_dur    break length in bit-times (stable while o_evt_valid)
//   i_evt_ready  consumer accepts the event
//   o_overrun    one-cycle pulse when a new event is dropped
//
// Event handshake: an event transfers in any cycle where o_evt_valid and
// i_evt_ready are both high at the clock edge. o_evt_dur does not change
// while o_evt_valid is high; a new event arriving while the old one is held
// and not being accepted is dropped (o_overrun), while one arriving in the
// same cycle the old one is accepted replaces it and valid stays high.
// -----------------------------------------------------------------------------
module break_detect
  import break_detect_pkg::*;
#(
  parameter int SYSCLK     = 12000000,
  parameter int BAUDRATE   = 115200,
  parameter int BREAK_BITS = DEF_BREAK_BITS,
  parameter int DUR_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rxd,
  output logic             o_break,
  output logic             o_start,
  output logic             o_end,
  output logic             o_evt_valid,
  output logic [DUR_W-1:0] o_evt_dur,
  input  logic             i_evt_ready,
  output logic             o_overrun
);

  localparam int               BIT_CYCLES = calc_bit_cycles(SYSCLK, BAUDRATE);
  localparam logic [DUR_W-1:0] DUR_MAX    = '1;
  localparam logic [DUR_W-1:0] BB_VAL     = DUR_W'(BREAK_BITS);

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BREAK_GLITCH_FILTER_EN
  logic r_flt0;
  logic r_flt1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flt0 <= 1'b1;
      r_flt1 <= 1'b1;
    end else begin
      r_flt0 <= r_sync2;
      r_flt1 <= r_flt0;
    end
  end

  // Majority of the three newest samples; a lone odd sample is outvoted.
  assign w_rx_s = (r_sync2 & r_flt0) | (r_sync2 & r_flt1) | (r_flt0 & r_flt1);
`else
  assign w_rx_s = r_sync2;
`endif

  // ---------------------------------------------------------------------------
  // Bit timing
  // Any high sample either keeps us in IDLE or returns us there, so clearing
  // on rx_s=1 holds the counters at 0 throughout IDLE. The low sample that
  // moves IDLE->LOW is the first sample of the run and is counted, which
  // makes the BREAK_BITS*BIT_CYCLES-th low sample the one that qualifies.
  // ---------------------------------------------------------------------------
  logic             w_bit_tick;
  logic [DUR_W-1:0] r_bits;
  logic [DUR_W-1:0] w_bits_nxt;

  baud_tick #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_baud_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_rx_s),
    .i_en    (~w_rx_s),
    .o_tick  (w_bit_tick)
  );

  assign w_bits_nxt = (r_bits == DUR_MAX) ? r_bits : (r_bits + 1'b1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bits <= '0;
    end else if (w_rx_s) begin
      r_bits <= '0;
    end else if (w_bit_tick) begin
      r_bits <= w_bits_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bit_tick && (w_bits_nxt == BB_VAL)) begin
          w_state_nxt = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from the transition, registered below so every
  // output changes in the cycle after the deciding rx_s sample)
  // ---------------------------------------------------------------------------
  logic w_start_nxt;
  logic w_end_nxt;
  logic w_break_nxt;

  always_comb begin
    w_start_nxt = 1'b0;
    w_end_nxt   = 1'b0;
    w_break_nxt = 1'b0;
    if ((r_state == ST_LOW) && (w_state_nxt == ST_BREAK)) begin
      w_start_nxt = 1'b1;
    end
    if ((r_state == ST_BREAK) && (w_state_nxt == ST_IDLE)) begin
      w_end_nxt = 1'b1;
    end
    if (w_state_nxt == ST_BREAK) begin
      w_break_nxt = 1'b1;
    end
  end

  logic r_break;
  logic r_start;
  logic r_end;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_break <= 1'b0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_break <= w_break_nxt;
      r_start <= w_start_nxt;
      r_end   <= w_end_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Event register (one deep). The event posts on the same decision as o_end,
  // capturing r_bits before the high sample clears it; the partial last bit
  // is never counted because r_bits only moves on whole bit-times.
  // ---------------------------------------------------------------------------
  logic             r_evt_valid;
  logic [DUR_W-1:0] r_evt_dur;
  logic             r_overrun;
  logic             w_hs;

  assign w_hs = r_evt_valid && i_evt_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_dur   <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_end_nxt) begin
        if (r_evt_valid && !w_hs) begin
          r_overrun <= 1'b1;
        end else begin
          r_evt_valid <= 1'b1;
          r_evt_dur   <= r_bits;
        end
      end else if (w_hs) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign o_break     = r_break;
  assign o_start     = r_start;
  assign o_end       = r_end;
  assign o_evt_valid = r_evt_valid;
  assign o_evt_dur   = r_evt_dur;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_break_detect.sv
module tb_break_detect;

  localparam int SYSCLK   = 1000;
  localparam int BAUDRATE = 100;
  localparam int BC       = 10;
  localparam int BB       = 10;
  localparam int DUR_W    = 4;
  localparam int TH       = BB * BC;
  localparam int DMAX     = 15;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             i_rst_n;
  logic             i_rxd;
  logic             o_break;
  logic             o_start;
  logic             o_end;
  logic             o_evt_valid;
  logic [DUR_W-1:0] o_evt_dur;
  logic             i_evt_ready;
  logic             o_overrun;

  always #5 clk = ~clk;

  break_detect #(
    .SYSCLK     (SYSCLK),
    .BAUDRATE   (BAUDRATE),
    .BREAK_BITS (BB),
    .DUR_W      (DUR_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_rxd       (i_rxd),
    .o_break     (o_break),
    .o_start     (o_start),
    .o_end       (o_end),
    .o_evt_valid (o_evt_valid),
    .o_evt_dur   (o_evt_dur),
    .i_evt_ready (i_evt_ready),
    .o_overrun   (o_overrun)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) begin
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks the length of the current low run of the
  // synchronized line and derives everything from that length.
  // ---------------------------------------------------------------------------
  bit hist[$];
  int run;
  bit m_valid;
  int m_dur;
  bit e_break, e_start, e_end, e_ovr;

  // Observations of DUT activity, used by the scenario checks.
  int n_start, n_end, n_ovr, n_hs, last_dur;

  task automatic model_reset();
    hist.delete();
    repeat (4) hist.push_back(1'b1);
    run     = 0;
    m_valid = 0;
    m_dur   = 0;
    e_break = 0;
    e_start = 0;
    e_end   = 0;
    e_ovr   = 0;
  endtask

  task automatic clear_obs();
    n_start  = 0;
    n_end    = 0;
    n_ovr    = 0;
    n_hs     = 0;
    last_dur = -1;
  endtask

  task automatic model_edge(input bit pin, input bit rdy);
    bit rxs;
    bit post;
    bit acc;
    int pd;
    int n;
    hist.push_back(pin);
    if (hist.size() > 8) void'(hist.pop_front());
    n = hist.size();
`ifdef BREAK_GLITCH_FILTER_EN
    rxs = (int'(hist[n-3]) + int'(hist[n-4]) + int'(hist[n-5])) >= 2;
`else
    rxs = hist[n-3];
`endif
    e_start = 0;
    e_end   = 0;
    e_ovr   = 0;
    post    = 0;
    pd      = 0;
    acc     = m_valid && rdy;
    if (!rxs) begin
      run++;
      if (run == TH) e_start = 1;
    end else begin
      if (run >= TH) begin
        e_end = 1;
        post  = 1;
        pd    = (run / BC > DMAX) ? DMAX : run / BC;
      end
      run = 0;
    end
    e_break = (run >= TH);
    if (post) begin
      if (m_valid && !acc) e_ovr = 1;
      else begin
        m_valid = 1;
        m_dur   = pd;
      end
    end else if (acc) begin
      m_valid = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Inputs change at the falling edge, outputs are
  // compared at the next falling edge.
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit pin, input bit rdy);
    i_rxd       = pin;
    i_evt_ready = rdy;
    #1;
    if (o_evt_valid && i_evt_ready) begin
      n_hs++;
      last_dur = int'(o_evt_dur);
    end
    @(posedge clk);
    model_edge(pin, rdy);
    @(negedge clk);
    check("o_break", int'(o_break), int'(e_break));
    check("o_start", int'(o_start), int'(e_start));
    check("o_end", int'(o_end), int'(e_end));
    check("o_overrun", int'(o_overrun), int'(e_ovr));
    check("o_evt_valid", int'(o_evt_valid), int'(m_valid));
    if (m_valid) check("o_evt_dur", int'(o_evt_dur), m_dur);
    if (o_start) n_start++;
    if (o_end) n_end++;
    if (o_overrun) n_ovr++;
  endtask

  task automatic hold(input bit pin, input int n, input bit rdy);
    for (int k = 0; k < n; k++) cycle(pin, rdy);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_break"}, int'(o_break), 0);
    check({tag, "_start"}, int'(o_start), 0);
    check({tag, "_end"}, int'(o_end), 0);
    check({tag, "_valid"}, int'(o_evt_valid), 0);
    check({tag, "_dur"}, int'(o_evt_dur), 0);
    check({tag, "_ovr"}, int'(o_overrun), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: low run length -> expected breaks and reported duration
  // ---------------------------------------------------------------------------
  typedef struct {
    int low_len;
    int exp_breaks;
    int exp_dur;
  } vec_t;

  vec_t tv[8];

  initial begin
    tv[0] = '{1,   0, -1};
    tv[1] = '{99,  0, -1};
    tv[2] = '{100, 1, 10};
    tv[3] = '{109, 1, 10};
    tv[4] = '{110, 1, 11};
    tv[5] = '{125, 1, 12};
    tv[6] = '{150, 1, 15};
    tv[7] = '{200, 1, 15};

    // Reset state
    i_rst_n     = 1'b0;
    i_rxd       = 1'b1;
    i_evt_ready = 1'b0;
    clear_obs();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    model_reset();
    hold(1'b1, 5, 1'b1);

    // Table-driven runs
    for (int v = 0; v < 8; v++) begin
      clear_obs();
      hold(1'b0, tv[v].low_len, 1'b1);
      hold(1'b1, 20, 1'b1);
      check("tv_starts", n_start, tv[v].exp_breaks);
      check("tv_ends", n_end, tv[v].exp_breaks);
      check("tv_events", n_hs, tv[v].exp_breaks);
      if (tv[v].exp_dur >= 0) check("tv_dur", last_dur, tv[v].exp_dur);
    end

    // Backpressure: second event dropped, first kept
    clear_obs();
    hold(1'b0, 100, 1'b0);
    hold(1'b1, 20, 1'b0);
    hold(1'b0, 100, 1'b0);
    hold(1'b1, 20, 1'b0);
    check("bp_overruns", n_ovr, 1);
    check("bp_valid_held", int'(o_evt_valid), 1);
    check("bp_dur_held", int'(o_evt_dur), 10);
    check("bp_no_hs_yet", n_hs, 0);
    cycle(1'b1, 1'b1);
    hold(1'b1, 5, 1'b0);
    check("bp_one_hs", n_hs, 1);
    check("bp_hs_dur", last_dur, 10);
    check("bp_valid_cleared", int'(o_evt_valid), 0);

    // Glitch inside a break
    clear_obs();
    hold(1'b0, 120, 1'b1);
    cycle(1'b1, 1'b1);
    hold(1'b0, 30, 1'b1);
    hold(1'b1, 20, 1'b1);
    check("gl_starts", n_start, 1);
    check("gl_ends", n_end, 1);
    check("gl_events", n_hs, 1);
`ifdef BREAK_GLITCH_FILTER_EN
    check("gl_dur", last_dur, 15);
`else
    check("gl_dur", last_dur, 12);
`endif

    // Reset in the middle of a break, line stays low afterwards
    clear_obs();
    hold(1'b0, 150, 1'b1);
    check("rst_pre_break", int'(o_break), 1);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    model_reset();
    clear_obs();
    hold(1'b0, 105, 1'b1);
    check("rst_restart_start", n_start, 1);
    check("rst_no_event", n_hs, 0);
    hold(1'b1, 20, 1'b1);
    check("rst_after_event", n_hs, 1);

    // Randomized runs with occasional glitches and random ready
    for (int r = 0; r < 25; r++) begin
      int len;
      int gap;
      len = $urandom_range(1, 220);
      gap = $urandom_range(1, 25);
      for (int k = 0; k < len; k++) begin
        cycle(($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)));
      end
      for (int k = 0; k < gap; k++) begin
        cycle(1'b1, 1'($urandom_range(0, 1)));
      end
    end
    hold(1'b1, 10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/break_detect.md
# break_detect

Receive-side counterpart of the serial terminal's break transmitter. It watches the PC receive line and detects a break condition: the line held low for at least `BREAK_BITS` bit-times, which is longer than any legal start+data+stop frame. It sits beside the PC UART on `RXD_PC` and drives two outputs:
- a level and pulses for the control/video path (for example, clearing the screen or flashing reverse video);
- a one-deep event stream that reports break duration in bit-times.

## Interface
- `SYSCLK`, 12000000: system clock frequency in Hz.
- `BAUDRATE`, 115200: line rate; `BIT_CYCLES = SYSCLK/BAUDRATE`, floor, minimum 2 (104 at defaults).
- `BREAK_BITS`, 10: consecutive low bit-times that qualify as a break.
- `DUR_W`, 16: width of the duration field; the count saturates.
- `i_clk` in 1: system clock (12 MHz).
- `i_rst_n` in 1: asynchronous, active-low reset. One clock, asynchronous active-low reset.
- `i_rxd` in 1: raw asynchronous RX line; idle high.
- `o_break` out 1: high while a break is in progress.
- `o_start` out 1: one-cycle pulse when a break qualifies.
- `o_end` out 1: one-cycle pulse when the line returns high after a break.
- `o_evt_valid` out 1: break-completed event is available.
- `o_evt_dur` out `DUR_W`: break length in whole bit-times, saturating.
- `i_evt_ready` in 1: consumer accepts the event.
- `o_overrun` out 1: one-cycle pulse when an event is dropped.

## Operation
- **Input path:** two-flop synchronizer on `i_rxd`, both flops reset to 1. The sampled line is `rx_s`.
- **Bit timing:** the cycle counter `cyc` runs 0..`BIT_CYCLES`-1 while `rx_s`=0. On wrap it emits `bit_tick`. The bit counter `bits` (`DUR_W` bits) increments on `bit_tick` and saturates at all-ones.
- **State IDLE:**
  - Counters are held at 0.
  - `rx_s`=0 → LOW.
- **State LOW:**
  - Counting runs.
  - `rx_s`=1 → IDLE. This is an ordinary character low period; no outputs change.
  - `bits` reaches `BREAK_BITS` (on the `bit_tick` that makes it so) → BREAK. Set `o_break`=1 and pulse `o_start`.
- **State BREAK:**
  - Counting continues.
  - `rx_s`=1 → IDLE. Clear `o_break`, pulse `o_end`, and post an event with `o_evt_dur`=`bits`. The partial final bit is discarded.
- **Event register, one deep:**
  - Handshake completes when valid and ready are both high in the same cycle.
  - `o_evt_dur` is stable while valid.
  - If a new event is posted while valid=1 and ready=0: the new event is dropped, the old one is kept, and `o_overrun` pulses.
  - If a new event is posted in the same cycle the old one is accepted: the new event loads and valid stays 1.
- **Counters:** `cyc` and `bits` clear on every entry to LOW.

## Timing
- Reset values:
  - state IDLE;
  - `o_break`, `o_start`, `o_end`, `o_evt_valid`, `o_overrun` = 0;
  - `o_evt_dur` = 0;
  - synchronizer flops = 1.
- Latency from a pin edge to `rx_s` is 2 cycles, or 3 with the filter enabled.
- `o_start` asserts in the cycle after the (`BREAK_BITS`·`BIT_CYCLES`)-th consecutive low `rx_s` sample. `o_break` rises in that same cycle.
- `o_end`, the fall of `o_break`, and the rise of `o_evt_valid` all occur in the cycle after the first high `rx_s` sample.
- A low run of exactly `BREAK_BITS`·`BIT_CYCLES`-1 samples is not a break.
- Reset asserted mid-break clears everything immediately and posts no event. If the line is still low after reset release, timing restarts from zero.
- Saturation: `bits` stays at 2^`DUR_W`-1. The break still ends and reports that value.

## Configuration
- `BREAK_GLITCH_FILTER_EN` defined:
  - adds a 3-sample majority filter after the synchronizer, 1 extra cycle of latency;
  - single-cycle glitches on `i_rxd` neither start LOW nor end BREAK.
- Undefined: `rx_s` is the synchronizer output directly, and a single high sample ends a break.

## Structure
- The shared package holds:
  - the state encoding (IDLE, LOW, BREAK);
  - the default `BREAK_BITS`;
  - the `BIT_CYCLES` derivation function, shared with the break transmitter so both ends agree on the threshold.
- One sub-module, `baud_tick`, contains the `cyc` counter with clear and enable inputs and produces `bit_tick`. The FSM, the bit counter and the event register stay in `break_detect`.

## Test plan
All scenarios use `SYSCLK`=1000, `BAUDRATE`=100 (so `BIT_CYCLES`=10), `BREAK_BITS`=10 and `DUR_W`=4.
- **Legal frame:** hold `i_rxd` low for 99 cycles, then high → no `o_start`, no event, state back to IDLE.
- **Minimal break:** hold low 100 cycles, then high → `o_start` 1 cycle after the 100th low sample, `o_end` later, event with `o_evt_dur`=10.
- **Long break with saturation:** hold low 200 cycles → `o_evt_dur`=15. Hold low 125 cycles with `DUR_W`=16 → `o_evt_dur`=12.
- **Backpressure:** two 100-cycle breaks separated by 20 high cycles with `i_evt_ready`=0 → first event kept (dur 10), `o_overrun` pulses once. Raising ready then completes exactly one handshake.
- **Reset mid-break:** pulse `i_rst_n` low at cycle 150 of a low run → all outputs 0, no event. Line held low 100 more cycles after release → new `o_start`.
- **Glitch with filter enabled:** 1-cycle high glitch at cycle 120 of a break → break continues, single event with dur ≥ 12. Without the filter → `o_end` at the glitch.
